// File: rtl/wb_reg_writer.sv
// Write-back commit unit: arbitrates ALU/load results into a small FIFO and emits
// them to the register file as single-cycle write pulses separated by an idle cycle.
// Optional build macro: WB_BYPASS_EN (empty-FIFO entries skip the FIFO for 1-edge latency).
//
// Handshake: a source transfers on the rising edge where x_valid && x_ready are both
// high; x_ready is combinational from the valids, the round-robin pointer and count.
module wb_reg_writer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  output logic [4:0]               reg_write,
  output logic [DATA_W-1:0]        data_write,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_WRITE} state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [4:0]          reg_write_q, reg_write_d;
  logic [DATA_W-1:0]   data_write_q, data_write_d;
  logic                pending_q, pending_d;

  logic [4:0]          fifo_rd_q   [DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [DEPTH];

  logic                full;
  logic                grant_alu;
  logic                grant_mem;
  logic                accept;
  logic [4:0]          acc_rd;
  logic [DATA_W-1:0]   acc_data;
  logic                pop;
  logic                push;
  logic                bypass;

  // Arbitration and acceptance; rr_q = 1 means the load side wins the next contest.
  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    grant_alu = alu_valid && (!mem_valid || !rr_q);
    grant_mem = mem_valid && (!alu_valid || rr_q);
    accept    = (grant_alu || grant_mem) && !full;
    acc_rd    = grant_alu ? alu_rd : mem_rd;
    acc_data  = grant_alu ? alu_data : mem_data;
    pop       = (state_q == ST_IDLE) && (count_q != '0);
`ifdef WB_BYPASS_EN
    bypass    = (state_q == ST_IDLE) && (count_q == '0) && accept && (acc_rd != 5'd0);
`else
    bypass    = 1'b0;
`endif
    // rd = 0 results are acknowledged but never stored.
    push      = accept && (acc_rd != 5'd0) && !bypass;
  end

  assign alu_ready = grant_alu && !full;
  assign mem_ready = grant_mem && !full;

  always_comb begin
    rr_d         = (accept && alu_valid && mem_valid) ? !rr_q : rr_q;
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    state_d      = state_q;
    reg_write_d  = reg_write_q;
    data_write_d = data_write_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d      = ST_WRITE;
          reg_write_d  = fifo_rd_q[rd_ptr_q];
          data_write_d = fifo_data_q[rd_ptr_q];
        end else if (bypass) begin
          state_d      = ST_WRITE;
          reg_write_d  = acc_rd;
          data_write_d = acc_data;
        end
      end
      ST_WRITE: begin
        // Forced idle cycle so back-to-back writes to one rd stay distinct events.
        state_d     = ST_IDLE;
        reg_write_d = 5'd0;
      end
      default: begin
        state_d     = ST_IDLE;
        reg_write_d = 5'd0;
      end
    endcase
    pending_d = (count_d != '0) || (state_d == ST_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_q         <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 5'd0;
      data_write_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      data_write_q <= data_write_d;
      pending_q    <= pending_d;
    end
  end

  // Storage needs no reset: count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= acc_rd;
      fifo_data_q[wr_ptr_q] <= acc_data;
    end
  end

  assign reg_write  = reg_write_q;
  assign data_write = data_write_q;
  assign count      = count_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_wb_reg_writer.sv
// Bench for wb_reg_writer: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations. Honours WB_BYPASS_EN.
module tb_wb_reg_writer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alu_valid = 1'b0;
  logic [4:0]        alu_rd = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              alu_ready;
  logic              mem_valid = 1'b0;
  logic [4:0]        mem_rd = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              mem_ready;
  logic [4:0]        reg_write;
  logic [DATA_W-1:0] data_write;
  logic [$clog2(DEPTH):0] count;
  logic              pending;

  wb_reg_writer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .reg_write(reg_write), .data_write(data_write), .count(count), .pending(pending)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              m_q[$];       // accepted, not yet emitted, in acceptance order
  logic [4:0]        m_rw = '0;    // write index currently shown to the register file
  logic [DATA_W-1:0] m_dw = '0;
  bit                m_rr = 0;     // 1: load side wins the next contest

  function automatic void model_grant(output bit ga, output bit gm);
    if (alu_valid && mem_valid) begin
      ga = !m_rr;
      gm = m_rr;
    end else begin
      ga = alu_valid;
      gm = mem_valid;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    ent_t e;
    ent_t h;
    bit ga, gm, acc, byp;
    if (!rst_n) begin
      m_q.delete();
      m_rw = '0;
      m_dw = '0;
      m_rr = 0;
    end else begin
      model_grant(ga, gm);
      acc = (ga || gm) && (m_q.size() < DEPTH);
      e.rd   = ga ? alu_rd : mem_rd;
      e.data = ga ? alu_data : mem_data;
      if (acc && alu_valid && mem_valid) m_rr = !m_rr;
      byp = 0;
      if (m_rw != 5'd0) begin
        m_rw = '0;
      end else if (m_q.size() != 0) begin
        h = m_q.pop_front();
        m_rw = h.rd;
        m_dw = h.data;
      end
`ifdef WB_BYPASS_EN
      else if (acc && e.rd != 5'd0) begin
        m_rw = e.rd;
        m_dw = e.data;
        byp = 1;
      end
`endif
      if (acc && e.rd != 5'd0 && !byp) m_q.push_back(e);
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin : compare
    bit ga, gm, full;
    if (chk_en) begin
      model_grant(ga, gm);
      full = (m_q.size() >= DEPTH);
      check("alu_ready", alu_ready, ga && !full);
      check("mem_ready", mem_ready, gm && !full);
      check("reg_write", reg_write, m_rw);
      check("data_write", data_write, m_dw);
      check("count", count, m_q.size());
      check("pending", pending, (m_q.size() != 0) || (m_rw != 5'd0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit av, input logic [4:0] ar, input logic [DATA_W-1:0] ad,
                        input bit mv, input logic [4:0] mr, input logic [DATA_W-1:0] md);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
  endtask

  task automatic idle_in();
    set_in(0, '0, '0, 0, '0, '0);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!pending && reg_write == 5'd0) done = 1;
    end
    check(name, done, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int pulses, run, max_run, c;
    bit found;
    logic [4:0] prev;

    idle_in();
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_reg_write", reg_write, 5'd0);
    check("reset_count", count, 0);
    check("reset_pending", pending, 0);

    // Single ALU result rd=5, 0xDEADBEEF.
    @(posedge clk); #1;
    set_in(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    @(posedge clk); #1;              // edge N: accepted
    idle_in();
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check("single_pulse", reg_write, 5'd5);
    check("single_data", data_write, 32'hDEADBEEF);
    check("single_count", count, 0);
`else
    check("single_wait", reg_write, 5'd0);
    check("single_count", count, 1);
    @(negedge clk);
    check("single_pulse", reg_write, 5'd5);
    check("single_data", data_write, 32'hDEADBEEF);
`endif
    @(negedge clk);
    check("single_gap", reg_write, 5'd0);
    check("single_hold", data_write, 32'hDEADBEEF);
    wait_idle("single_drain");

    // Two consecutive writes to rd=7, both data 0x1.
    @(posedge clk); #1;
    set_in(1, 5'd7, 32'h1, 0, '0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle_in();
    pulses = 0; run = 0; max_run = 0; prev = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (reg_write == 5'd7) begin
        run++;
        if (prev != 5'd7) pulses++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      prev = reg_write;
    end
    check("rd7_pulses", pulses, 2);
    check("rd7_single_cycle", max_run, 1);

    // rd = 0 is acknowledged but dropped.
    @(posedge clk); #1;
    set_in(1, 5'd0, 32'h55, 0, '0, '0);
    @(negedge clk);
    check("rd0_ready", alu_ready, 1);
    @(posedge clk); #1;
    idle_in();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rd0_count", count, 0);
      check("rd0_pending", pending, 0);
      check("rd0_no_write", reg_write, 5'd0);
    end

    // Both sources every cycle until full; round-robin starts at ALU.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      set_in(1, 5'(1 + i), 32'hA000 + i, 1, 5'(16 + i), 32'hB000 + i);
      @(negedge clk);
      if (i == 0) begin
        check("rr_first_alu", alu_ready, 1);
        check("rr_first_mem", mem_ready, 0);
      end
      if (i == 1) begin
        check("rr_second_alu", alu_ready, 0);
        check("rr_second_mem", mem_ready, 1);
      end
      if (count == DEPTH) found = 1;
    end
    check("fill_reached_full", found, 1);
    check("full_alu_ready", alu_ready, 0);
    check("full_mem_ready", mem_ready, 0);
    #1;
    set_in(0, '0, '0, 1, 5'd30, 32'hC0DE);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (count == DEPTH) check("pop_full_mem_ready", mem_ready, 0);
      else if (count == DEPTH - 1) begin
        check("after_pop_mem_ready", mem_ready, 1);
        found = 1;
      end
    end
    check("pop_reached_3", found, 1);
    #1;
    idle_in();
    wait_idle("fill_drain");

    // Asynchronous reset while reg_write = 9, with more entries queued behind it.
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(posedge clk); #1;
      if (k < 4) set_in(1, 5'(9 + k), 32'h90 + k, 0, '0, '0);
      else idle_in();
      @(negedge clk);
      if (reg_write == 5'd9) found = 1;
    end
    check("rst_saw_rd9", found, 1);
    #1;
    idle_in();
    rst_n = 1'b0;
    #1;
    check("rst_reg_write", reg_write, 5'd0);
    check("rst_data_write", data_write, 0);
    check("rst_count", count, 0);
    check("rst_pending", pending, 0);
    @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", reg_write, 5'd0);
      check("post_rst_count", count, 0);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      c = $urandom_range(0, 9);
      set_in($urandom_range(0, 2) != 0,
             (c == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
             $urandom_range(0, 2) != 0,
             (c == 1) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
    end
    @(posedge clk); #1;
    idle_in();
    wait_idle("final_drain");
    check("final_count", count, 0);
    check("final_pending", pending, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
